// File: rtl/fma_dot_seq.sv
// -----------------------------------------------------------------------------
// fma_dot_seq
//   Sequencer that computes a dot product by driving a single-precision FMA
//   unit through its start/done handshake: acc = a_i*b_i + acc, with acc
//   seeded by a bias. This block does no floating-point math itself.
//
// Optional feature macro: FMA_DOT_TIMEOUT_EN
//   Defined   -> a watchdog aborts a stuck FMA wait after TIMEOUT_CYC cycles,
//                finishing with dot_err = 1 and the partial sum.
//   Undefined -> no watchdog; dot_err is tied low.
//
// Ports
//   clk, rst_n             clock (rising edge), async active-low reset
//   cmd_start, len, bias   command: element count (clamped to N_MAX), seed
//   elem_valid/ready/a/b   element-pair stream handshake
//   fma_start, fma_a/b/c   issue pulse and operands to the FMA (a*b + c)
//   fma_result, fma_done   FMA answer and completion pulse
//   busy                   command in progress
//   dot_done, dot_result   one-cycle completion pulse, held final sum
//   dot_err                watchdog timeout flag, valid with dot_done
// -----------------------------------------------------------------------------
module fma_dot_seq #(
    parameter int N_MAX       = 16,
    parameter int LEN_W       = 5,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_start,
    input  logic [LEN_W-1:0] len,
    input  logic [31:0]      bias,
    input  logic             elem_valid,
    input  logic [31:0]      elem_a,
    input  logic [31:0]      elem_b,
    output logic             elem_ready,
    output logic             fma_start,
    output logic [31:0]      fma_a,
    output logic [31:0]      fma_b,
    output logic [31:0]      fma_c,
    input  logic [31:0]      fma_result,
    input  logic             fma_done,
    output logic             busy,
    output logic             dot_done,
    output logic [31:0]      dot_result,
    output logic             dot_err
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ELEM,
        ISSUE,
        WAIT_FMA,
        FINISH
    } state_t;

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(N_MAX);

    state_t           state, state_nxt;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] count;
    logic [LEN_W-1:0] count_inc;
    logic [LEN_W-1:0] len_clamped;
    logic [31:0]      acc;
    logic             last_elem;
    logic             timeout;

    assign len_clamped = (len > LEN_MAX) ? LEN_MAX : len;
    assign count_inc   = count + LEN_W'(1);
    assign last_elem   = (count_inc == len_q);

`ifdef FMA_DOT_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] wdog;

    // Counter sits at zero outside WAIT_FMA, so it is cleared on every entry.
    // Firing at TIMEOUT_CYC-1 puts FINISH exactly TIMEOUT_CYC cycles after entry.
    assign timeout = (state == WAIT_FMA) && !fma_done &&
                     (wdog == WD_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog    <= '0;
            dot_err <= 1'b0;
        end else begin
            wdog <= (state == WAIT_FMA) ? wdog + WD_W'(1) : '0;
            if (state == IDLE && cmd_start) begin
                dot_err <= 1'b0;
            end else if (timeout) begin
                dot_err <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYC;
    assign timeout            = 1'b0;
    assign dot_err            = 1'b0;
`endif

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt  = state;
        elem_ready = 1'b0;
        fma_start  = 1'b0;
        dot_done   = 1'b0;
        busy       = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (cmd_start) begin
                    state_nxt = (len_clamped == '0) ? FINISH : WAIT_ELEM;
                end
            end
            WAIT_ELEM: begin
                elem_ready = 1'b1;
                if (elem_valid) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                fma_start = 1'b1;
                state_nxt = WAIT_FMA;
            end
            WAIT_FMA: begin
                if (fma_done) begin
                    state_nxt = last_elem ? FINISH : WAIT_ELEM;
                end else if (timeout) begin
                    state_nxt = FINISH;
                end
            end
            FINISH: begin
                dot_done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // dot_result is loaded on the edge that enters FINISH so that it is
    // already valid during the dot_done cycle, then held until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q      <= '0;
            count      <= '0;
            acc        <= '0;
            fma_a      <= '0;
            fma_b      <= '0;
            fma_c      <= '0;
            dot_result <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_start) begin
                        len_q <= len_clamped;
                        acc   <= bias;
                        count <= '0;
                        if (len_clamped == '0) begin
                            dot_result <= bias;
                        end
                    end
                end
                WAIT_ELEM: begin
                    if (elem_valid) begin
                        fma_a <= elem_a;
                        fma_b <= elem_b;
                        fma_c <= acc;
                    end
                end
                WAIT_FMA: begin
                    if (fma_done) begin
                        acc   <= fma_result;
                        count <= count_inc;
                        if (last_elem) begin
                            dot_result <= fma_result;
                        end
                    end else if (timeout) begin
                        dot_result <= acc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fma_dot_seq.sv
// -----------------------------------------------------------------------------
// tb_fma_dot_seq
//   Scoreboard bench for fma_dot_seq. Stimulus pushes expected FMA issues and
//   expected dot results into queues; monitors pop and compare whenever the
//   DUT pulses fma_start or dot_done. Operands are small integers encoded as
//   IEEE-754 singles so the FMA model and reference sums stay exact.
// -----------------------------------------------------------------------------
module tb_fma_dot_seq;

    localparam int N_MAX       = 16;
    localparam int LEN_W       = 5;
    localparam int TIMEOUT_CYC = 40;
    localparam int ELEM_BUDGET = 100;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_start;
    logic [LEN_W-1:0] len;
    logic [31:0]      bias;
    logic             elem_valid;
    logic [31:0]      elem_a, elem_b;
    logic             elem_ready;
    logic             fma_start;
    logic [31:0]      fma_a, fma_b, fma_c;
    logic [31:0]      fma_result;
    logic             fma_done;
    logic             model_done;
    logic             spur_done;
    logic             busy, dot_done, dot_err;
    logic [31:0]      dot_result;

    assign fma_done = model_done | spur_done;

    always #5 clk = ~clk;

    fma_dot_seq #(.N_MAX(N_MAX), .LEN_W(LEN_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_start(cmd_start), .len(len), .bias(bias),
        .elem_valid(elem_valid), .elem_a(elem_a), .elem_b(elem_b),
        .elem_ready(elem_ready), .fma_start(fma_start),
        .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c),
        .fma_result(fma_result), .fma_done(fma_done),
        .busy(busy), .dot_done(dot_done), .dot_result(dot_result), .dot_err(dot_err)
    );

    typedef struct packed { logic [31:0] a, b, c; } issue_t;
    typedef struct packed { logic [31:0] res; logic err; } res_t;

    issue_t issue_q[$];
    res_t   res_q[$];

    int checks   = 0;
    int failures = 0;
    int fma_lat  = 1;
    bit fma_mute = 0;
    int start_cnt = 0;
    logic [31:0] last_result = '0;
    logic [31:0] last_c      = '0;
    logic        prev_done   = 1'b0;
    int ea[N_MAX];
    int eb[N_MAX];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Exact integer <-> IEEE-754 single conversion for |v| < 2^24.
    function automatic logic [31:0] i2f(int v);
        logic [31:0] mag, sh, r;
        int p;
        if (v == 0) return 32'h0;
        mag = (v < 0) ? 32'(-v) : 32'(v);
        p = 0;
        for (int i = 0; i < 32; i++) if (mag[i]) p = i;
        sh        = mag << (23 - p);
        r[31]     = (v < 0);
        r[30:23]  = 8'(127 + p);
        r[22:0]   = sh[22:0];
        return r;
    endfunction

    function automatic int f2i(logic [31:0] f);
        int e, v;
        logic [31:0] m;
        if (f[30:23] == 8'd0) return 0;
        e = int'(f[30:23]) - 127;
        m = {8'd0, 1'b1, f[22:0]};
        v = int'(m >> (23 - e));
        return f[31] ? -v : v;
    endfunction

    // Behavioural FMA with programmable latency; also watches operand hold.
    initial begin
        logic [31:0] oa, ob, oc;
        logic hold_ok, aborted;
        model_done = 1'b0;
        fma_result = '0;
        forever begin
            @(negedge clk);
            if (rst_n && fma_start) begin
                oa = fma_a; ob = fma_b; oc = fma_c;
                hold_ok = 1'b1; aborted = 1'b0;
                for (int i = 0; i < fma_lat; i++) begin
                    @(negedge clk);
                    if (!rst_n || !busy) aborted = 1'b1;
                    else hold_ok &= (fma_a == oa) && (fma_b == ob) && (fma_c == oc);
                end
                if (!aborted) check("fma_operand_hold", 32'(hold_ok), 1);
                if (!fma_mute) begin
                    fma_result = i2f(f2i(oa) * f2i(ob) + f2i(oc));
                    model_done = 1'b1;
                    @(negedge clk);
                    model_done = 1'b0;
                end
            end
        end
    end

    // Monitor: pops expectations when the DUT presents an issue or a result.
    always @(negedge clk) begin
        if (rst_n) begin
            if (fma_start) begin
                start_cnt++;
                last_c = fma_c;
                check("issue_expected", 32'(issue_q.size() > 0), 1);
                if (issue_q.size() > 0) begin
                    issue_t e;
                    e = issue_q.pop_front();
                    check("issue_a", fma_a, e.a);
                    check("issue_b", fma_b, e.b);
                    check("issue_c", fma_c, e.c);
                end
            end
            if (dot_done) begin
                last_result = dot_result;
                check("dot_done_width", 32'(prev_done), 0);
                check("result_expected", 32'(res_q.size() > 0), 1);
                if (res_q.size() > 0) begin
                    res_t r;
                    r = res_q.pop_front();
                    check("dot_result", dot_result, r.res);
                    check("dot_err", 32'(dot_err), 32'(r.err));
                end
            end
        end
        prev_done = dot_done;
    end

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("cmd_completes", 32'(busy), 0);
    endtask

    task automatic feed_elem(int i, bit stall);
        int budget;
        if (stall) begin
            elem_valid = 1'b0;
            budget = 0;
            while (!elem_ready && budget < ELEM_BUDGET) begin
                @(negedge clk);
                budget++;
            end
            for (int s = 0; s < 5; s++) begin
                check("stall_ready", 32'(elem_ready), 1);
                check("stall_no_issue", 32'(fma_start), 0);
                cmd_start = (s == 1);
                len       = '0;
                bias      = 32'h3F80_0000;
                spur_done = (s == 2);
                @(negedge clk);
            end
            cmd_start = 1'b0;
            spur_done = 1'b0;
        end
        elem_valid = 1'b1;
        elem_a     = i2f(ea[i]);
        elem_b     = i2f(eb[i]);
        budget = 0;
        while (!elem_ready && budget < ELEM_BUDGET) begin
            @(negedge clk);
            budget++;
        end
        check("elem_accepted", 32'(elem_ready), 1);
        @(negedge clk);
        // Keep junk on the stream: it must not be consumed outside WAIT_ELEM.
        elem_a = $urandom;
        elem_b = $urandom;
    endtask

    task automatic run_cmd(int n_req, int bias_i, bit stall);
        int n, acc;
        issue_t it;
        res_t r;
        n   = (n_req > N_MAX) ? N_MAX : n_req;
        acc = bias_i;
        for (int i = 0; i < n; i++) begin
            it.a = i2f(ea[i]); it.b = i2f(eb[i]); it.c = i2f(acc);
            issue_q.push_back(it);
            acc += ea[i] * eb[i];
        end
        r.res = i2f(acc); r.err = 1'b0;
        res_q.push_back(r);
        @(negedge clk);
        cmd_start = 1'b1;
        len       = LEN_W'(n_req);
        bias      = i2f(bias_i);
        @(negedge clk);
        cmd_start = 1'b0;
        len       = LEN_W'($urandom);
        bias      = $urandom;
        check("busy_after_start", 32'(busy), 1);
        check("err_cleared", 32'(dot_err), 0);
        if (n == 0) begin
            check("zero_len_done", 32'(dot_done), 1);
            @(negedge clk);
            check("zero_len_busy_clear", 32'(busy), 0);
        end
        for (int i = 0; i < n; i++) feed_elem(i, stall);
        wait_idle();
        check("issue_q_drained", 32'(issue_q.size()), 0);
        check("res_q_drained", 32'(res_q.size()), 0);
    endtask

    task automatic check_reset_values();
        check("rst_elem_ready", 32'(elem_ready), 0);
        check("rst_fma_start", 32'(fma_start), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_dot_done", 32'(dot_done), 0);
        check("rst_dot_err", 32'(dot_err), 0);
        check("rst_fma_a", fma_a, 0);
        check("rst_fma_b", fma_b, 0);
        check("rst_fma_c", fma_c, 0);
        check("rst_dot_result", dot_result, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int s0, n;
        rst_n = 1'b0; cmd_start = 1'b0; len = '0; bias = '0;
        elem_valid = 1'b0; elem_a = '0; elem_b = '0; spur_done = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;

        // Single element: 4 + 2*3 = 10.
        fma_lat = 4; ea[0] = 2; eb[0] = 3;
        s0 = start_cnt;
        run_cmd(1, 4, 0);
        check("single_c", last_c, 32'h4080_0000);
        check("single_result", last_result, 32'h4120_0000);
        check("single_starts", 32'(start_cnt - s0), 1);

        // Two elements: 4 + 2*3 + 3*4 = 22.
        fma_lat = 1; ea[1] = 3; eb[1] = 4;
        s0 = start_cnt;
        run_cmd(2, 4, 0);
        check("two_second_c", last_c, 32'h4120_0000);
        check("two_result", last_result, 32'h41B0_0000);
        check("two_starts", 32'(start_cnt - s0), 2);

        // Zero length.
        s0 = start_cnt;
        run_cmd(0, 1, 0);
        check("zero_result", last_result, 32'h3F80_0000);
        check("zero_starts", 32'(start_cnt - s0), 0);

        // Stalls with spurious cmd_start/fma_done, long FMA latency.
        fma_lat = 10;
        for (int i = 0; i < 3; i++) begin
            ea[i] = int'($urandom_range(0, 40)) - 20;
            eb[i] = int'($urandom_range(0, 40)) - 20;
        end
        run_cmd(3, -7, 1);

        // Reset during WAIT_FMA; the model's late done must be ignored.
        fma_lat = 10; ea[0] = 2; eb[0] = 3;
        begin
            issue_t it;
            it.a = i2f(2); it.b = i2f(3); it.c = i2f(4);
            issue_q.push_back(it);
        end
        @(negedge clk);
        cmd_start = 1'b1; len = LEN_W'(3); bias = i2f(4);
        @(negedge clk);
        cmd_start = 1'b0;
        feed_elem(0, 0);
        elem_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_values();
        issue_q.delete();
        res_q.delete();
        @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("post_reset_idle_busy", 32'(busy), 0);
        check("post_reset_idle_ready", 32'(elem_ready), 0);
        fma_lat = 3; ea[0] = 2; eb[0] = 3;
        run_cmd(1, 4, 0);
        check("post_reset_result", last_result, 32'h4120_0000);

        // Clamp: len above N_MAX consumes exactly N_MAX elements.
        fma_lat = 1;
        for (int i = 0; i < N_MAX; i++) begin
            ea[i] = int'($urandom_range(0, 40)) - 20;
            eb[i] = int'($urandom_range(0, 40)) - 20;
        end
        s0 = start_cnt;
        run_cmd(N_MAX + 4, 3, 0);
        check("clamp_starts", 32'(start_cnt - s0), 32'(N_MAX));

        // Randomized commands.
        for (int c = 0; c < 25; c++) begin
            n = int'($urandom_range(0, N_MAX + 3));
            for (int i = 0; i < N_MAX; i++) begin
                ea[i] = int'($urandom_range(0, 40)) - 20;
                eb[i] = int'($urandom_range(0, 40)) - 20;
            end
            fma_lat = int'($urandom_range(1, 10));
            run_cmd(n, int'($urandom_range(0, 200)) - 100, ($urandom_range(0, 3) == 0));
        end

`ifdef FMA_DOT_TIMEOUT_EN
        // Watchdog: FMA never answers; partial sum (the bias) is reported.
        fma_mute = 1; fma_lat = 1; ea[0] = 5; eb[0] = 5;
        begin
            issue_t it;
            res_t r;
            it.a = i2f(5); it.b = i2f(5); it.c = i2f(7);
            issue_q.push_back(it);
            r.res = i2f(7); r.err = 1'b1;
            res_q.push_back(r);
        end
        @(negedge clk);
        cmd_start = 1'b1; len = LEN_W'(2); bias = i2f(7);
        @(negedge clk);
        cmd_start = 1'b0;
        feed_elem(0, 0);
        elem_valid = 1'b0;
        check("wd_issue", 32'(fma_start), 1);
        n = 0;
        while (!dot_done && n < TIMEOUT_CYC + 20) begin
            @(negedge clk);
            n++;
        end
        check("wd_latency", 32'(n), 32'(TIMEOUT_CYC + 1));
        check("wd_err", 32'(dot_err), 1);
        check("wd_result", dot_result, i2f(7));
        wait_idle();
        fma_mute = 0;
        ea[0] = 2; eb[0] = 3;
        run_cmd(1, 4, 0);
        check("wd_recover_result", last_result, 32'h4120_0000);
`endif

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
